// File: rtl/serial_alu_defs.sv
// Shared definitions for the bit-serial ALU path: opcode values and sequencer state encoding.
package serial_alu_defs;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 2'd3 is unused; the sequencer treats it as a fault and returns to idle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between the ALU op decoder (master) and the serial add/sub sequencer (slave).
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, carryout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/serial_addsub_ctrl_add_sub.sv
// Shared 1-bit add/sub full-adder cell; subtraction is handled upstream by inverting B and seeding carry.
module add_sub (
  output logic sum,
  output logic carryout,
  input  logic A,
  input  logic B,
  input  logic carryin
);
  assign sum      = A ^ B ^ carryin;
  assign carryout = (A & B) | (carryin & (A ^ B));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer: one bit per cycle, LSB first, through a single add_sub cell.
module serial_addsub_ctrl
  import serial_alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  serial_addsub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             cin_q, cmsb_q, co_q, ov_q;
  logic             cell_sum, cell_co;

  add_sub u_cell (cell_sum, cell_co, a_q[0], b_q[0], cin_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      cmsb_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // subtract as a + ~b + 1: invert B here, the +1 rides in on the first carry
            a_q     <= bus.a;
            b_q     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            cin_q   <= bus.op;
            cnt_q   <= '0;
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {cell_sum, res_q[WIDTH-1:1]};
          cin_q <= cell_co;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 2)) cmsb_q <= cell_co;
          if (cnt_q == CW'(WIDTH - 1)) begin
            co_q    <= cell_co;
            ov_q    <= cmsb_q ^ cell_co;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.carryout = co_q;
  assign bus.overflow = ov_q;
  assign bus.zero     = (res_q == '0);
endmodule
